// File: rtl/full_handshake_rx_buf.sv
// rtl/full_handshake_rx_buf.sv - four-phase req/ack receiver with show-ahead FIFO
module full_handshake_rx_buf #(
    parameter int DW          = 32,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_i,
    input  logic [DW-1:0]            req_data_i,
    output logic                     ack_o,
    output logic [DW-1:0]            recv_data_o,
    output logic                     recv_valid_o,
    input  logic                     recv_ready_i,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [15:0]              xfer_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    // One-hot style encoding leaves illegal codes that the FSM must recover from
    typedef enum logic [1:0] {
        ST_IDLE = 2'b01,
        ST_ACK  = 2'b10
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    state_t                 state_q, state_d;
    logic                   ack_q, ack_d;
    logic                   push;
    logic                   pop;
    logic [DW-1:0]          mem_q [DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]          level_q, level_d;
    logic [15:0]            xfer_cnt_q, xfer_cnt_d;
    logic                   not_empty;

    assign req_s     = sync_q[SYNC_STAGES-1];
    assign not_empty = (level_q != '0);
    assign pop       = not_empty && recv_ready_i;

    // Request synchroniser: the only logic that samples the asynchronous req_i
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_i};
        end
    end

    // Handshake FSM next state: accept only when a slot is free in the registered level
    always_comb begin
        state_d = ST_IDLE;
        ack_d   = 1'b0;
        push    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_s && (level_q != FULL_LVL)) begin
                    push    = 1'b1;
                    ack_d   = 1'b1;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (req_s) begin
                    ack_d   = 1'b1;
                    state_d = ST_ACK;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ack_d   = 1'b0;
            end
        endcase
    end

    // Handshake FSM state and ack register; ack comes straight from this flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
        end
    end

    // FIFO pointer, occupancy and transfer-count next state
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        xfer_cnt_d = xfer_cnt_q;
        if (push) begin
            wr_ptr_d   = wr_ptr_q + AW'(1);
            xfer_cnt_d = xfer_cnt_q + 16'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // FIFO bookkeeping registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            xfer_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    // FIFO storage; contents need no reset since an empty FIFO reads as zero
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= req_data_i;
        end
    end

    assign ack_o        = ack_q;
    assign recv_valid_o = not_empty;
    assign recv_data_o  = not_empty ? mem_q[rd_ptr_q] : '0;
    assign level_o      = level_q;
    assign xfer_cnt_o   = xfer_cnt_q;

endmodule
